// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, state encoding and round helper functions
package sha256_pkg;

   localparam int WORDS_IN_CHUNK = 16;
   localparam int DIGEST_WORDS   = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROUND  = 2'd1,
      UPDATE = 2'd2,
      DIGEST = 2'd3
   } compressor_state_t;

   localparam logic [31:0] H_INIT [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Big sigma 0, applied to working variable a
   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
   endfunction

   // Big sigma 1, applied to working variable e
   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
   endfunction

   // Small sigma 0, message schedule expansion
   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   // Small sigma 1, message schedule expansion
   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
module sha256_round
   import sha256_pkg::*;
(
   input  logic [7:0][31:0] state_in,
   input  logic [31:0]      k,
   input  logic [31:0]      w,
   output logic [7:0][31:0] state_out
);

   // Word 0 is a, word 7 is h
   logic [31:0] t1;
   logic [31:0] t2;

   // Standard round: two temporaries, then rotate the working variables
   always_comb begin
      t1 = state_in[7] + bsig1(state_in[4]) + ch(state_in[4], state_in[5], state_in[6]) + k + w;
      t2 = bsig0(state_in[0]) + maj(state_in[0], state_in[1], state_in[2]);
      state_out[0] = t1 + t2;
      state_out[1] = state_in[0];
      state_out[2] = state_in[1];
      state_out[3] = state_in[2];
      state_out[4] = state_in[3] + t1;
      state_out[5] = state_in[4];
      state_out[6] = state_in[5];
      state_out[7] = state_in[6];
   end

endmodule

// File: rtl/sha256_compressor.sv
// rtl/sha256_compressor.sv - SHA-256 chunk compressor with hash accumulation and digest output
module sha256_compressor
   import sha256_pkg::*;
#(
   parameter int UNROLL = 1
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   output logic                                    chunk_in_rdy,
   input  logic                                    chunk_in_vld,
   input  logic [WORDS_IN_CHUNK-1:0][31:0]         chunk_in,
   input  logic                                    chunk_in_last,
   input  logic                                    digest_rdy,
   output logic                                    digest_vld,
   output logic [DIGEST_WORDS-1:0][31:0]           digest,
   output logic                                    busy
);

   // UNROLL must divide 64 evenly (1, 2 or 4) so the last step lands on t = 63
   compressor_state_t                       state;
   logic [5:0]                              t;
   logic [WORDS_IN_CHUNK-1:0][31:0]         w_win;
   logic [DIGEST_WORDS-1:0][31:0]           hv;
   logic [DIGEST_WORDS-1:0][31:0]           wv;
   logic [DIGEST_WORDS-1:0][31:0]           round_out;
   logic [DIGEST_WORDS-1:0][31:0]           h_sum;
   logic                                    last_q;
   logic [WORDS_IN_CHUNK+UNROLL-1:0][31:0]  ext;

   // Window extended by the UNROLL words needed after this step; later words may
   // depend on earlier new ones, so they are built in order inside one function
   function automatic logic [WORDS_IN_CHUNK+UNROLL-1:0][31:0] extend(input logic [WORDS_IN_CHUNK-1:0][31:0] win);
      logic [WORDS_IN_CHUNK+UNROLL-1:0][31:0] e;
      e = '0;
      e[WORDS_IN_CHUNK-1:0] = win;
      for (int j = 0; j < UNROLL; j++) begin
         e[16+j] = ssig1(e[14+j]) + e[9+j] + ssig0(e[1+j]) + e[j];
      end
      return e;
   endfunction

   assign ext = extend(w_win);

   // Chain of UNROLL rounds; window word i feeds round t+i
   for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
      logic [DIGEST_WORDS-1:0][31:0] s_in;
      logic [DIGEST_WORDS-1:0][31:0] s_out;
      if (i == 0) begin : g_first
         assign s_in = wv;
      end else begin : g_next
         assign s_in = g_rnd[i-1].s_out;
      end
      sha256_round u_round (
         .state_in  (s_in),
         .k         (K[t + 6'(i)]),
         .w         (ext[i]),
         .state_out (s_out)
      );
   end

   assign round_out = g_rnd[UNROLL-1].s_out;

   // Chunk result folded into the running hash, mod 2^32 per word
   always_comb begin
      h_sum = '0;
      for (int i = 0; i < DIGEST_WORDS; i++) begin
         h_sum[i] = hv[i] + wv[i];
      end
   end

   // Control FSM with registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         t            <= '0;
         w_win        <= '0;
         wv           <= '0;
         last_q       <= 1'b0;
         chunk_in_rdy <= 1'b0;
         digest_vld   <= 1'b0;
         digest       <= '0;
         busy         <= 1'b0;
         for (int i = 0; i < DIGEST_WORDS; i++) begin
            hv[i] <= H_INIT[i];
         end
      end else begin
         case (state)
            IDLE: begin
               if (chunk_in_rdy && chunk_in_vld) begin
                  w_win        <= chunk_in;
                  last_q       <= chunk_in_last;
                  wv           <= hv;
                  t            <= '0;
                  chunk_in_rdy <= 1'b0;
                  busy         <= 1'b1;
                  state        <= ROUND;
               end else begin
                  chunk_in_rdy <= 1'b1;
               end
            end
            ROUND: begin
               wv    <= round_out;
               w_win <= ext[UNROLL +: WORDS_IN_CHUNK];
               t     <= t + 6'(UNROLL);
               if (t == 6'(64 - UNROLL)) begin
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               hv <= h_sum;
               if (last_q) begin
                  digest     <= h_sum;
                  digest_vld <= 1'b1;
                  state      <= DIGEST;
               end else begin
                  chunk_in_rdy <= 1'b1;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end
            end
            DIGEST: begin
               if (digest_rdy) begin
                  digest_vld   <= 1'b0;
                  chunk_in_rdy <= 1'b1;
                  busy         <= 1'b0;
                  state        <= IDLE;
                  for (int i = 0; i < DIGEST_WORDS; i++) begin
                     hv[i] <= H_INIT[i];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_compressor.sv
// tb/tb_sha256_compressor.sv - directed scoreboard bench for sha256_compressor
module tb_sha256_compressor;

   localparam int UNROLL = 1;
   localparam int LAT    = 64 / UNROLL + 2;

   logic              clk;
   logic              rst_n;
   logic              chunk_in_rdy;
   logic              chunk_in_vld;
   logic [15:0][31:0] chunk_in;
   logic              chunk_in_last;
   logic              digest_rdy;
   logic              digest_vld;
   logic [7:0][31:0]  digest;
   logic              busy;

   int errors = 0;
   int checks = 0;
   logic [255:0] sb [$];

   sha256_compressor #(.UNROLL(UNROLL)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .chunk_in_rdy  (chunk_in_rdy),
      .chunk_in_vld  (chunk_in_vld),
      .chunk_in      (chunk_in),
      .chunk_in_last (chunk_in_last),
      .digest_rdy    (digest_rdy),
      .digest_vld    (digest_vld),
      .digest        (digest),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reading-order literal (W0 in the top bits) to word-indexed chunk
   function automatic logic [15:0][31:0] ck(input logic [511:0] lit);
      logic [15:0][31:0] r;
      for (int i = 0; i < 16; i++) r[i] = lit[511-32*i -: 32];
      return r;
   endfunction

   // Reading-order literal (H0 in the top bits) to word-indexed digest
   function automatic logic [255:0] dg(input logic [255:0] lit);
      logic [7:0][31:0] r;
      for (int i = 0; i < 8; i++) r[i] = lit[255-32*i -: 32];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Offer a chunk and return #1 after the transfer edge with vld dropped
   task automatic send_chunk(input logic [15:0][31:0] c, input logic last);
      int n;
      n = 0;
      @(negedge clk);
      chunk_in = c;
      chunk_in_last = last;
      chunk_in_vld = 1'b1;
      while (!chunk_in_rdy && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("chunk_accept", 256'(chunk_in_rdy), 256'(1));
      @(posedge clk);
      #1 chunk_in_vld = 1'b0;
   endtask

   // Called #1 after a last-chunk transfer; checks latency, value and handshake
   task automatic get_digest(input string tag, input bit rdy_early);
      int cyc;
      logic [255:0] exp;
      cyc = 1;
      if (rdy_early) digest_rdy = 1'b1;
      while (!digest_vld && cyc < 400) begin
         @(posedge clk);
         #1 cyc++;
      end
      chk({tag, "_lat"}, 256'(cyc), 256'(LAT));
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      chk(tag, digest, exp);
      if (!rdy_early) begin
         @(negedge clk);
         digest_rdy = 1'b1;
      end
      @(posedge clk);
      #1 digest_rdy = 1'b0;
      chk({tag, "_vld_drop"}, 256'(digest_vld), 256'(0));
      chk({tag, "_rdy_back"}, 256'(chunk_in_rdy), 256'(1));
   endtask

   logic [15:0][31:0] c_abc, c_empty, c_two1, c_two2;
   logic [255:0]      d_abc, d_empty, d_two, held;
   int                cyc, bad;
   bit                seen;

   initial begin
      c_abc   = ck({32'h61626380, 448'h0, 32'h00000018});
      c_empty = ck({32'h80000000, 480'h0});
      c_two1  = ck({32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000});
      c_two2  = ck({480'h0, 32'h000001c0});
      d_abc   = dg(256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
      d_empty = dg(256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855);
      d_two   = dg(256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);

      rst_n = 1'b0;
      chunk_in_vld = 1'b0;
      chunk_in = '0;
      chunk_in_last = 1'b0;
      digest_rdy = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_chunk_in_rdy", 256'(chunk_in_rdy), 256'(0));
      chk("rst_digest_vld", 256'(digest_vld), 256'(0));
      chk("rst_digest", digest, 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk("rdy_after_reset", 256'(chunk_in_rdy), 256'(1));

      // "abc", single chunk
      sb.push_back(d_abc);
      send_chunk(c_abc, 1'b1);
      chk("busy_in_round", 256'(busy), 256'(1));
      get_digest("abc", 1'b0);

      // Empty message, digest_rdy raised before digest_vld
      sb.push_back(d_empty);
      send_chunk(c_empty, 1'b1);
      get_digest("empty", 1'b1);

      // Two-chunk message: no digest after the first chunk
      send_chunk(c_two1, 1'b0);
      cyc = 1;
      seen = 1'b0;
      while (!chunk_in_rdy && cyc < 400) begin
         @(posedge clk);
         #1 cyc++;
         if (digest_vld) seen = 1'b1;
      end
      chk("two_rdy_lat", 256'(cyc), 256'(LAT));
      chk("two_no_mid_digest", 256'(seen), 256'(0));
      sb.push_back(d_two);
      send_chunk(c_two2, 1'b1);
      get_digest("two", 1'b0);

      // Backpressure on the digest with a chunk offered meanwhile
      sb.push_back(d_abc);
      send_chunk(c_abc, 1'b1);
      cyc = 1;
      while (!digest_vld && cyc < 400) begin
         @(posedge clk);
         #1 cyc++;
      end
      chk("bp_lat", 256'(cyc), 256'(LAT));
      held = digest;
      @(negedge clk);
      chunk_in = c_abc;
      chunk_in_last = 1'b1;
      chunk_in_vld = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!(digest_vld === 1'b1 && digest === held && chunk_in_rdy === 1'b0 && busy === 1'b1)) bad++;
      end
      chk("bp_stall", 256'(bad), 256'(0));
      chk("bp_digest", digest, sb.pop_front());
      sb.push_back(d_abc);
      digest_rdy = 1'b1;
      @(posedge clk);
      #1 digest_rdy = 1'b0;
      chk("bp_vld_drop", 256'(digest_vld), 256'(0));
      chk("bp_rdy_back", 256'(chunk_in_rdy), 256'(1));
      @(posedge clk);
      #1 chunk_in_vld = 1'b0;
      chk("bp_taken", 256'(chunk_in_rdy), 256'(0));
      get_digest("bp_rearm_abc", 1'b0);

      // Reset in the middle of the rounds of a first chunk
      send_chunk(c_two1, 1'b0);
      repeat (30 / UNROLL) @(posedge clk);
      @(negedge clk);
      chk("pre_reset_busy", 256'(busy), 256'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_chunk_in_rdy", 256'(chunk_in_rdy), 256'(0));
      chk("mid_rst_digest_vld", 256'(digest_vld), 256'(0));
      chk("mid_rst_digest", digest, 256'(0));
      chk("mid_rst_busy", 256'(busy), 256'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sb.push_back(d_abc);
      send_chunk(c_abc, 1'b1);
      get_digest("post_rst_abc", 1'b0);

      chk("sb_empty", 256'(sb.size()), 256'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
